// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller command path:
// opcode byte values and the command decoder state encoding.
package sys_ctrl_pkg;

    localparam logic [7:0] OPC_RF_WR    = 8'hAA;
    localparam logic [7:0] OPC_RF_RD    = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP   = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP  = 8'hDD;
    localparam logic [7:0] OPC_BURST_WR = 8'hEE;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WR_ADDR    = 4'd1,
        ST_WR_DATA    = 4'd2,
        ST_RD_ADDR    = 4'd3,
        ST_ALU_A      = 4'd4,
        ST_ALU_B      = 4'd5,
        ST_ALU_FUN    = 4'd6,
        ST_BURST_ADDR = 4'd7,
        ST_BURST_LEN  = 4'd8,
        ST_BURST_DATA = 4'd9
    } state_t;

endpackage

// File: rtl/sys_ctrl_idle_timer.sv
// Loadable down-counter that saturates at zero; a count of zero means expired.
// Serves both the inter-byte timeout and the ALU clock-hold window.
module sys_ctrl_idle_timer #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count
);

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/sys_cmd_decoder.sv
// UART receive-side command decoder: turns framed command bytes into register
// file and ALU strobes, with range checks, burst writes and an inter-byte timeout.
module sys_cmd_decoder
    import sys_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int OPA_ADDR    = 0,
    parameter int OPB_ADDR    = 1,
    parameter int MAX_BURST   = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter int ALU_HOLD    = 2,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_Data,
    input  logic             RX_D_VLD,
    output logic             WrEn,
    output logic             RdEn,
    output logic [AW-1:0]    Addr,
    output logic [WIDTH-1:0] Wr_D,
    output logic [3:0]       ALU_FUN,
    output logic             ALU_EN,
    output logic             CLK_EN,
    output logic             Cmd_Err,
    output logic             Tmo_Err
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int HW = (ALU_HOLD > 0) ? $clog2(ALU_HOLD + 1) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [WIDTH:0]  DEPTH_X   = (WIDTH + 1)'(DEPTH);
    localparam logic [WIDTH:0]  MAXB_X    = (WIDTH + 1)'(MAX_BURST);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0]   OPA       = AW'(OPA_ADDR);
    localparam logic [AW-1:0]   OPB       = AW'(OPB_ADDR);
    localparam logic [TW-1:0]   TMO_LOAD  = TW'(TIMEOUT_CYC - 1);
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(ALU_HOLD);
    localparam logic            HOLD_ON   = (ALU_HOLD != 0);

    state_t state;
    state_t next_state;

    logic [AW-1:0]    frame_addr;
    logic [AW-1:0]    frame_addr_nxt;
    logic [BW-1:0]    beats;
    logic [BW-1:0]    beats_nxt;

    logic             wr_en_nxt;
    logic             rd_en_nxt;
    logic             alu_en_nxt;
    logic             cmd_err_nxt;
    logic             tmo_err_nxt;
    logic             clk_en_nxt;
    logic [AW-1:0]    addr_nxt;
    logic [WIDTH-1:0] wr_d_nxt;
    logic [3:0]       alu_fun_nxt;

    logic [WIDTH:0]   byte_ext;
    logic             byte_addr_bad;
    logic             byte_len_bad;
    logic [AW-1:0]    byte_addr;
    logic [BW-1:0]    byte_len;

    logic             tmo_load;
    logic [TW-1:0]    tmo_count;
    logic [HW-1:0]    hold_count;

    assign byte_ext      = {1'b0, RX_P_Data};
    assign byte_addr_bad = (byte_ext >= DEPTH_X);
    assign byte_len_bad  = (RX_P_Data == '0) || (byte_ext > MAXB_X);
    assign byte_addr     = RX_P_Data[AW-1:0];
    assign byte_len      = RX_P_Data[BW-1:0];

    // The idle count is held at its reload value in IDLE and on every received byte.
    assign tmo_load = (state == ST_IDLE) || RX_D_VLD;

    sys_ctrl_idle_timer #(.W(TW)) u_tmo_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmo_load),
        .load_val (TMO_LOAD),
        .dec      (1'b1),
        .count    (tmo_count)
    );

    // Hold window starts the cycle after the ALU_EN pulse, so CLK_EN spans ALU_HOLD+1 cycles.
    sys_ctrl_idle_timer #(.W(HW)) u_hold_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (ALU_EN),
        .load_val (HOLD_LOAD),
        .dec      (1'b1),
        .count    (hold_count)
    );

    // CLK_EN is registered, so predict whether the hold counter is non-zero next cycle.
    assign clk_en_nxt = alu_en_nxt | (ALU_EN & HOLD_ON) | (hold_count > HW'(1));

    // Next-state and next-output decode; a byte arriving in the expiry cycle wins.
    always_comb begin
        next_state     = state;
        frame_addr_nxt = frame_addr;
        beats_nxt      = beats;
        wr_en_nxt      = 1'b0;
        rd_en_nxt      = 1'b0;
        alu_en_nxt     = 1'b0;
        cmd_err_nxt    = 1'b0;
        tmo_err_nxt    = 1'b0;
        addr_nxt       = Addr;
        wr_d_nxt       = Wr_D;
        alu_fun_nxt    = ALU_FUN;

        if (RX_D_VLD) begin
            case (state)
                ST_IDLE: begin
                    if (RX_P_Data == WIDTH'(OPC_RF_WR)) begin
                        next_state = ST_WR_ADDR;
                    end else if (RX_P_Data == WIDTH'(OPC_RF_RD)) begin
                        next_state = ST_RD_ADDR;
                    end else if (RX_P_Data == WIDTH'(OPC_ALU_OP)) begin
                        next_state = ST_ALU_A;
                    end else if (RX_P_Data == WIDTH'(OPC_ALU_NOP)) begin
                        next_state = ST_ALU_FUN;
                    end else if (RX_P_Data == WIDTH'(OPC_BURST_WR)) begin
                        next_state = ST_BURST_ADDR;
                    end else begin
                        cmd_err_nxt = 1'b1;
                    end
                end
                ST_WR_ADDR, ST_BURST_ADDR: begin
                    if (byte_addr_bad) begin
                        cmd_err_nxt = 1'b1;
                        next_state  = ST_IDLE;
                    end else begin
                        frame_addr_nxt = byte_addr;
                        next_state     = (state == ST_WR_ADDR) ? ST_WR_DATA : ST_BURST_LEN;
                    end
                end
                ST_WR_DATA: begin
                    wr_en_nxt  = 1'b1;
                    addr_nxt   = frame_addr;
                    wr_d_nxt   = RX_P_Data;
                    next_state = ST_IDLE;
                end
                ST_RD_ADDR: begin
                    if (byte_addr_bad) begin
                        cmd_err_nxt = 1'b1;
                    end else begin
                        rd_en_nxt = 1'b1;
                        addr_nxt  = byte_addr;
                    end
                    next_state = ST_IDLE;
                end
                ST_ALU_A: begin
                    wr_en_nxt  = 1'b1;
                    addr_nxt   = OPA;
                    wr_d_nxt   = RX_P_Data;
                    next_state = ST_ALU_B;
                end
                ST_ALU_B: begin
                    wr_en_nxt  = 1'b1;
                    addr_nxt   = OPB;
                    wr_d_nxt   = RX_P_Data;
                    next_state = ST_ALU_FUN;
                end
                ST_ALU_FUN: begin
                    alu_fun_nxt = RX_P_Data[3:0];
                    alu_en_nxt  = 1'b1;
                    next_state  = ST_IDLE;
                end
                ST_BURST_LEN: begin
                    if (byte_len_bad) begin
                        cmd_err_nxt = 1'b1;
                        next_state  = ST_IDLE;
                    end else begin
                        beats_nxt  = byte_len;
                        next_state = ST_BURST_DATA;
                    end
                end
                ST_BURST_DATA: begin
                    wr_en_nxt = 1'b1;
                    addr_nxt  = frame_addr;
                    wr_d_nxt  = RX_P_Data;
                    beats_nxt = beats - BW'(1);
                    // Explicit wrap keeps non-power-of-two depths in range.
                    if (frame_addr == LAST_ADDR) begin
                        frame_addr_nxt = '0;
                    end else begin
                        frame_addr_nxt = frame_addr + AW'(1);
                    end
                    if (beats == BW'(1)) begin
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_BURST_DATA;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end else if ((state != ST_IDLE) && (tmo_count == '0)) begin
            tmo_err_nxt = 1'b1;
            next_state  = ST_IDLE;
        end else begin
            next_state = state;
        end
    end

    // State, frame context and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            frame_addr <= '0;
            beats      <= '0;
            WrEn       <= 1'b0;
            RdEn       <= 1'b0;
            Addr       <= '0;
            Wr_D       <= '0;
            ALU_FUN    <= 4'd0;
            ALU_EN     <= 1'b0;
            CLK_EN     <= 1'b0;
            Cmd_Err    <= 1'b0;
            Tmo_Err    <= 1'b0;
        end else begin
            state      <= next_state;
            frame_addr <= frame_addr_nxt;
            beats      <= beats_nxt;
            WrEn       <= wr_en_nxt;
            RdEn       <= rd_en_nxt;
            Addr       <= addr_nxt;
            Wr_D       <= wr_d_nxt;
            ALU_FUN    <= alu_fun_nxt;
            ALU_EN     <= alu_en_nxt;
            CLK_EN     <= clk_en_nxt;
            Cmd_Err    <= cmd_err_nxt;
            Tmo_Err    <= tmo_err_nxt;
        end
    end

endmodule

// File: doc/sys_cmd_decoder.md
# sys_cmd_decoder

Parametrised successor to the system controller's UART receive-side command FSM. Accepts framed command bytes from the UART RX deserialiser and drives the register file (write, read, burst write) and the ALU (with or without operands, plus gated-clock enable). New over the previous generation: configurable width, depth and operand addresses, burst write, address range checking, an inter-byte timeout, and a programmable ALU clock-hold window.

## Interface
- WIDTH, 8, data/command byte width (≥ 8)
- DEPTH, 16, register file depth; AW = $clog2(DEPTH)
- OPA_ADDR, 0, register file address of ALU operand A
- OPB_ADDR, 1, register file address of ALU operand B
- MAX_BURST, 8, maximum burst length (1..DEPTH)
- TIMEOUT_CYC, 1024, idle cycles inside a frame before abort (≥ 2)
- ALU_HOLD, 2, cycles CLK_EN stays high after the ALU_EN pulse
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, synchronous and active-high
- RX_P_Data  in  WIDTH  received byte, valid when RX_D_VLD = 1
- RX_D_VLD  in  1  one-cycle strobe per byte; back-to-back strobes allowed
- WrEn  out  1  register file write strobe
- RdEn  out  1  register file read strobe
- Addr  out  AW  register file address
- Wr_D  out  WIDTH  register file write data
- ALU_FUN  out  4  ALU function (RX_P_Data[3:0])
- ALU_EN  out  1  ALU start strobe
- CLK_EN  out  1  ALU clock-gate enable
- Cmd_Err  out  1  one-cycle pulse: bad opcode, address ≥ DEPTH, or illegal burst length
- Tmo_Err  out  1  one-cycle pulse: frame aborted by timeout

## Operation
- All outputs are registered. Reset value of every output is 0. Reset state is IDLE, and all counters are cleared.
- The first byte is the opcode, decoded in IDLE. There is no separate decode state.
- Frames:
  - 0xAA: WR_ADDR → WR_DATA → one WrEn pulse.
  - 0xBB: RD_ADDR → one RdEn pulse.
  - 0xCC: ALU_A (write to OPA_ADDR) → ALU_B (write to OPB_ADDR) → ALU_FUN → ALU_EN pulse.
  - 0xDD: ALU_FUN → ALU_EN pulse.
  - 0xEE: BURST_ADDR → BURST_LEN → BURST_DATA, with N WrEn pulses at Addr, Addr+1, …
- Any other opcode: pulse Cmd_Err and stay in IDLE.
- Address bytes ≥ DEPTH: pulse Cmd_Err, return to IDLE, issue no strobe.
- Burst length of 0 or > MAX_BURST: pulse Cmd_Err, return to IDLE.
- Burst addressing increments modulo DEPTH, wrapping DEPTH-1 → 0. Data beats are counted by a down-counter, and the FSM returns to IDLE after the Nth WrEn.
- Addr and Wr_D hold their last values between strobes. Upper bits of RX_P_Data beyond AW or 4 are ignored once range-checked.
- CLK_EN = ALU_EN | (hold counter ≠ 0). The hold counter loads ALU_HOLD on each ALU_EN. The FSM returns to IDLE immediately, so a new frame may start during the hold window. A second ALU_EN reloads the counter.
- Timeout: an idle counter runs in every non-IDLE state and reloads on each RX_D_VLD. When it reaches TIMEOUT_CYC, the FSM pulses Tmo_Err, goes to IDLE and emits no strobe. RX_D_VLD in the expiry cycle wins: the byte is consumed and there is no error.
- RST asserted mid-frame aborts the frame and drops all strobes, CLK_EN and the hold counter on the following edge.

## Timing
- Each strobe (WrEn, RdEn, ALU_EN, Cmd_Err, Tmo_Err) is exactly one cycle wide. It asserts on the edge after the sampling edge of the final byte, i.e. latency is 1 cycle.
- Addr and Wr_D are valid in the same cycle as their strobe.
- During a 0xCC frame, the OPA_ADDR write appears 1 cycle after byte 2 and the OPB_ADDR write 1 cycle after byte 3.
- With back-to-back RX_D_VLD, a burst produces one WrEn per cycle with no gap.

## Structure
- Shared package sys_ctrl_pkg holds:
  - opcode constants (OPC_RF_WR, OPC_RF_RD, OPC_ALU_OP, OPC_ALU_NOP, OPC_BURST_WR);
  - state encodings for IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, BURST_ADDR, BURST_LEN, BURST_DATA.
- Sub-module sys_ctrl_idle_timer: load, decrement and expire logic, parametrised by width, used for both the timeout and ALU_HOLD counters.

## Test plan
- AA,05,3C back-to-back → WrEn = 1 for one cycle, Addr = 5, Wr_D = 0x3C; BB,05 → RdEn = 1, Addr = 5.
- CC,11,22,01 → WrEn at Addr 0 with 0x11, then Addr 1 with 0x22, then ALU_EN with ALU_FUN = 1; CLK_EN high for 3 cycles (ALU_HOLD = 2).
- EE,0E,03,A1,A2,A3 at DEPTH = 16 → three consecutive WrEn cycles at Addr 14, 15, 0 with data A1, A2, A3.
- 7F → Cmd_Err pulse with no strobes; AA,20 (DEPTH = 16) → Cmd_Err, no WrEn; EE,00,00 → Cmd_Err.
- AA,05 then silence for TIMEOUT_CYC cycles → Tmo_Err pulse and return to IDLE; a following BB,02 decodes normally. RX_D_VLD arriving in the expiry cycle → no Tmo_Err.
- RST asserted mid-burst after 2 of 4 beats → all outputs 0 on the next edge; a following DD,03 gives ALU_EN with ALU_FUN = 3.
